// File: rtl/arm_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : arm_pkg
// Brief    : Shared types and constants for the CPU data-memory path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package arm_pkg;

  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_t;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sram_controller
// Brief    : Splits 32-bit CPU loads/stores into two 16-bit SRAM phases.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module sram_controller
  import arm_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int               c_CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_CYCLES - 1);

  sram_state_t               r_state;
  sram_state_t               w_next_state;
  logic [c_CNT_W-1:0]        r_cnt;
  logic                      r_is_wr;
  logic [31:0]               r_read_data;
  logic                      w_phase_last;
  logic [31:0]               w_offset;
  logic [16:0]               w_word;
  logic                      w_unused_offset;
  logic                      w_active;
  logic                      w_dq_oe;
  logic [SRAM_DATA_W-1:0]    w_dq_out;
  logic                      w_addr_lsb;
  logic                      w_ready;
  logic                      w_we_n;
  logic                      w_oe_n;

  // Word index wraps at 17 bits; byte-lane bits are don't-care.
  assign w_offset        = address - DATA_BASE;
  assign w_word          = w_offset[18:2];
  assign w_unused_offset = ^{w_offset[31:19], w_offset[1:0]};
  assign w_phase_last    = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (rd_en || wr_en) w_next_state = ST_LOW;
      ST_LOW:  if (w_phase_last)   w_next_state = ST_HIGH;
      ST_HIGH: if (w_phase_last)   w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_active   = (r_state == ST_LOW) || (r_state == ST_HIGH);
    w_addr_lsb = (r_state == ST_HIGH);
    w_dq_oe    = w_active && r_is_wr;
    w_we_n     = !(w_active && r_is_wr);
    w_oe_n     = !(w_active && !r_is_wr);
    w_dq_out   = (r_state == ST_HIGH) ? write_data[31:16] : write_data[15:0];
    w_ready    = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = !(rd_en || wr_en);
      ST_DONE: w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state != w_next_state) || !w_active) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Access type is frozen when leaving IDLE so it cannot flip mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr <= 1'b0;
    end else if ((r_state == ST_IDLE) && (rd_en || wr_en)) begin
      r_is_wr <= wr_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= '0;
    end else if (!r_is_wr && w_phase_last) begin
      if (r_state == ST_LOW) begin
        r_read_data[15:0] <= SRAM_DQ;
      end else if (r_state == ST_HIGH) begin
        r_read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_ADDR = {w_word, w_addr_lsb};
  assign SRAM_WE_N = w_we_n;
  assign SRAM_OE_N = w_oe_n;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign ready     = w_ready;
  assign read_data = r_read_data;

endmodule : sram_controller
`default_nettype wire

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WAIT_CYCLES, default 2: cycles per 16-bit SRAM phase; legal range 1..15.
REQ-003 Parameter DATA_BASE, default 1024: byte address of SRAM word 0 in the CPU data map.
REQ-004 Ports SHALL be exactly these:
- clk  in  1  system clock.
- rst  in  1  async active-high reset.
- rd_en  in  1  MEM-stage read request.
- wr_en  in  1  MEM-stage write request.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  load data to MEM_Reg.
- ready  out  1  access complete; pipeline freezes while 0.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_WE_N  out  1  write strobe, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, LOW, HIGH, DONE.
REQ-006 IDLE transitions: on rd_en|wr_en go to LOW; otherwise stay in IDLE.
REQ-007 LOW transitions: go to HIGH after WAIT_CYCLES cycles in LOW.
REQ-008 HIGH transitions: go to DONE after WAIT_CYCLES cycles in HIGH.
REQ-009 DONE transitions: always go to IDLE after one cycle.
REQ-010 A wait counter of width ceil(log2(WAIT_CYCLES+1)) SHALL clear on every phase entry.
REQ-011 ready SHALL be combinational:
- 1 in IDLE with no request.
- 0 in IDLE with a request.
- 0 in LOW and HIGH.
- 1 in DONE.
REQ-012 Latency: for a request first seen in cycle 0, ready=1 in cycle 2*WAIT_CYCLES+1 (cycle 5 for the default), for both reads and writes.
REQ-013 The requester SHALL hold address, write_data, rd_en and wr_en stable until ready=1. The block SHALL sample these inputs continuously and SHALL NOT latch them.
REQ-014 A new request present in the cycle after DONE SHALL start a new access; back-to-back accesses have no extra idle cycle.
REQ-015 Address mapping:
- word = (address - DATA_BASE) >> 2, truncated to 17 bits.
- SRAM_ADDR = {word, 0} in LOW; {word, 1} in HIGH.
- Bits above the 17-bit word index are ignored (wrap-around).
REQ-016 Write phases:
- SRAM_DQ = write_data[15:0] in LOW and write_data[31:16] in HIGH.
- SRAM_WE_N = 0 for every cycle of LOW and HIGH.
- SRAM_OE_N = 1.
REQ-017 Read phases:
- SRAM_OE_N = 0 in LOW and HIGH.
- SRAM_DQ is high-Z.
- read_data[15:0] is registered on the last LOW cycle; read_data[31:16] on the last HIGH cycle.
- read_data holds its value until the next read updates it.
REQ-018 Outside LOW and HIGH:
- SRAM_DQ is high-Z.
- SRAM_WE_N = 1 and SRAM_OE_N = 1.
- SRAM_ADDR holds the word address with LSB 0.
REQ-019 If rd_en and wr_en are both 1, the access SHALL be a write.
REQ-020 A write SHALL never modify read_data.
REQ-021 The access type is decided on IDLE exit and SHALL NOT change mid-access.

Reset
REQ-022 rst=1 SHALL force, asynchronously:
- state = IDLE, counter = 0, read_data = 0.
- SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ released.
REQ-023 A reset during LOW or HIGH SHALL abort the access. Half-written SRAM contents are not restored; ready follows the IDLE rule after reset is released.

Structure
REQ-024 The following SHALL live in the shared arm_pkg package:
- the state typedef;
- SRAM_ADDR_W = 18 and SRAM_DATA_W = 16;
- the DATA_BASE default.
REQ-025 No sub-module is required. The wait counter and tri-state driver SHALL be inline; a behavioural SRAM model (sram_model) is bench-only.

Verification
REQ-026 Write, then read back:
- Write address=1024, data=0xDEADBEEF, WAIT_CYCLES=2 -> SRAM half-word 0 = 0xBEEF, half-word 1 = 0xDEAD; ready=1 in cycle 5; WE_N low for cycles 1-4.
- Then read address=1024 -> read_data=0xDEADBEEF in the DONE cycle; ready low for exactly 5 cycles.
REQ-027 Back-to-back requests: write 1028=0x12345678, then immediately read 1028 -> second access starts in the cycle after DONE; read_data=0x12345678; SRAM_ADDR = 2 then 3.
REQ-028 Simultaneous request: rd_en=wr_en=1, address=1032, data=0xA5A5A5A5 -> write performed (WE_N low, OE_N high); read_data unchanged.
REQ-029 Reset mid-access: rst asserted in the second HIGH cycle of a read -> same cycle: WE_N=1, OE_N=1, DQ high-Z, read_data=0; after release with no request: ready=1, state IDLE.
REQ-030 Parameter sweep: WAIT_CYCLES=1 and WAIT_CYCLES=15 -> ready latency of 3 and 31 cycles respectively; address=1024+4*131072 wraps to SRAM_ADDR=0.
